binary_counter: RTL and testbench
=================================

Name: binary_counter

Overview:
- Programmable 6-bit up/down counter with synchronous clear, parallel load, hold, selectable step size, and wrap-or-saturate mode.
- Produces a registered one-cycle `result` pulse whenever a count operation overflows or underflows the 6-bit range.
- Used as a general-purpose event/position counter; all control is sampled on the rising clock edge from a 32-bit configuration word `b` plus single-bit strobes.

Parameters:
- none (width fixed at 6 bits; `b` fixed at 32 bits)

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- x  input  1  count enable
- y  input  1  direction: 1 = up, 0 = down
- a  input  1  parallel load strobe
- c  input  1  synchronous clear strobe
- d  input  1  step select: 0 = step of 1, 1 = step of b[21:16]
- g  input  1  hold (freeze counter)
- f  input  1  mode: 1 = saturate, 0 = wrap modulo 64
- b  input  32  config word: b[5:0] load value, b[21:16] programmable step; all other bits ignored
- count  output  6  current counter value (registered)
- result  output  1  registered overflow/underflow pulse

Behaviour:
- Reset:
  - reset = 0 asynchronously forces count = 0 and result = 0, independent of clock.
  - The block leaves reset on the first rising edge after reset returns to 1.
- Per rising edge, the first true condition in this priority order applies:
  1. c = 1: count <= 0; result <= 0.
  2. a = 1: count <= b[5:0]; result <= 0.
  3. g = 1: count unchanged; result <= 0.
  4. x = 1: count operation (below).
  5. Otherwise: count unchanged; result <= 0.
- Count operation:
  - step = (d ? b[21:16] : 1).
  - Compute with 7-bit signed or extended arithmetic:
    - up: next = count + step
    - down: next = count - step
  - In range (0..63): count <= next; result <= 0.
  - Out of range with f = 0 (wrap): count <= next mod 64 (low 6 bits); result <= 1.
  - Out of range with f = 1 (saturate): count <= 63 for up, 0 for down; result <= 1.
  - Saturate mode at a limit: with count = 63 counting up, count stays 63 and result <= 1 on every enabled cycle. Same at 0 counting down.
  - step = 0 (d = 1, b[21:16] = 0): count unchanged; result <= 0.
- result:
  - Pulse, registered, high for exactly the one cycle following each out-of-range operation.
  - Stays high on consecutive cycles only if each of those cycles produces an out-of-range operation.
- Inputs are sampled only at the clock edge; mid-cycle changes have no effect.
- An unknown (X) control input has undefined effect; the bench drives all inputs to known values.
- No handshake and no latency beyond one clock: count reflects the edge's operation immediately after that edge.

Test Plan:
- Reset behaviour: hold reset = 0 with x = 1, y = 1 for 3 edges -> count = 0, result = 0. Release reset, x = 1, y = 1, d = 0 -> count 1, 2, 3 on successive edges.
- Wrap up: load b[5:0] = 62, then x = 1, y = 1, f = 0, d = 0 -> count 63 (result 0), then 0 (result 1), then 1 (result 0).
- Saturate down with step: load 5, then d = 1, b[21:16] = 4, y = 0, f = 1, x = 1 -> count 1 (result 0), 0 (result 1), 0 (result 1).
- Priority:
  - c = 1, a = 1, x = 1 with count = 20 -> count = 0.
  - a = 1, g = 1, b[5:0] = 33 -> count = 33.
  - g = 1, x = 1 -> count holds at 33, result 0.
- Wrap down with large step: count = 3, d = 1, b[21:16] = 10, y = 0, f = 0, x = 1 -> count = 57, result = 1.
- Asynchronous reset mid-run: counting up at count = 40, assert reset = 0 between edges -> count = 0 and result = 0 immediately, before the next edge.

Source files
------------

// File: rtl/binary_counter.sv
// 6-bit programmable up/down counter with clear, load, hold, selectable step
// and wrap-or-saturate mode; result pulses for one cycle on over/underflow.
module binary_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        x,
    input  logic        y,
    input  logic        a,
    input  logic        c,
    input  logic        d,
    input  logic        g,
    input  logic        f,
    input  logic [31:0] b,
    output logic [5:0]  count,
    output logic        result
);

    logic        [5:0] step_p0;
    logic signed [7:0] sum_p0;
    logic        [5:0] cnt_nxt_p0;
    logic              res_nxt_p0;
    logic              unused_b;

    assign unused_b = ^{b[31:22], b[15:6]};

    function automatic logic out_of_range(input logic signed [7:0] v);
        return (v < 8'sd0) || (v > 8'sd63);
    endfunction

    // Wrap keeps the low six bits; saturate pins to the limit in the count direction.
    function automatic logic [5:0] wrap_or_sat(input logic signed [7:0] v,
                                               input logic up,
                                               input logic sat);
        logic [5:0] r;
        if (!out_of_range(v))
            r = v[5:0];
        else if (sat)
            r = up ? 6'd63 : 6'd0;
        else
            r = v[5:0];
        return r;
    endfunction

    // Stage 0: step selection, extended-range arithmetic and priority decode
    always_comb begin
        step_p0 = d ? b[21:16] : 6'd1;
        if (y)
            sum_p0 = $signed({2'b00, count}) + $signed({2'b00, step_p0});
        else
            sum_p0 = $signed({2'b00, count}) - $signed({2'b00, step_p0});

        cnt_nxt_p0 = count;
        res_nxt_p0 = 1'b0;
        if (c) begin
            cnt_nxt_p0 = 6'd0;
        end else if (a) begin
            cnt_nxt_p0 = b[5:0];
        end else if (g) begin
            cnt_nxt_p0 = count;
        end else if (x) begin
            cnt_nxt_p0 = wrap_or_sat(sum_p0, y, f);
            res_nxt_p0 = out_of_range(sum_p0);
        end
    end

    // Stage 1: registered count and over/underflow pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count  <= 6'd0;
            result <= 1'b0;
        end else begin
            count  <= cnt_nxt_p0;
            result <= res_nxt_p0;
        end
    end

endmodule

// File: tb/tb_binary_counter.sv
// Directed bench for binary_counter: hand-computed count/result after each edge.
module tb_binary_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        x, y, a, c, d, g, f;
    logic [31:0] b;
    logic [5:0]  count;
    logic        result;

    int passed = 0;
    int total  = 0;

    binary_counter dut (
        .clock  (clock),
        .reset  (reset),
        .x      (x),
        .y      (y),
        .a      (a),
        .c      (c),
        .d      (d),
        .g      (g),
        .f      (f),
        .b      (b),
        .count  (count),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp_cnt, input logic exp_res);
        total++;
        assert (count === exp_cnt && result === exp_res) passed++;
        else $error("FAIL %s: count=%0d result=%0b expected count=%0d result=%0b",
                    tag, count, result, exp_cnt, exp_res);
    endtask

    task automatic set_ctl(input logic nx, input logic ny, input logic na, input logic nc,
                           input logic nd, input logic ng, input logic nf);
        x = nx; y = ny; a = na; c = nc; d = nd; g = ng; f = nf;
    endtask

    initial begin
        reset = 1'b0;
        b = 32'd0;
        set_ctl(1, 1, 0, 0, 0, 0, 0);

        // reset held low while counting is requested
        tick(); check("rst_hold0", 6'd0, 1'b0);
        tick(); check("rst_hold1", 6'd0, 1'b0);
        tick(); check("rst_hold2", 6'd0, 1'b0);
        reset = 1'b1;
        tick(); check("up1", 6'd1, 1'b0);
        tick(); check("up2", 6'd2, 1'b0);
        tick(); check("up3", 6'd3, 1'b0);

        // wrap up
        set_ctl(0, 1, 1, 0, 0, 0, 0); b = 32'd62;
        tick(); check("load62", 6'd62, 1'b0);
        set_ctl(1, 1, 0, 0, 0, 0, 0);
        tick(); check("wrap_up63", 6'd63, 1'b0);
        tick(); check("wrap_up0", 6'd0, 1'b1);
        tick(); check("wrap_up1", 6'd1, 1'b0);

        // saturate down with step 4
        set_ctl(0, 0, 1, 0, 0, 0, 0); b = 32'd5;
        tick(); check("load5", 6'd5, 1'b0);
        set_ctl(1, 0, 0, 0, 1, 0, 1); b = 32'd4 << 16;
        tick(); check("satdn1", 6'd1, 1'b0);
        tick(); check("satdn0a", 6'd0, 1'b1);
        tick(); check("satdn0b", 6'd0, 1'b1);

        // priority
        set_ctl(0, 1, 1, 0, 0, 0, 0); b = 32'd20;
        tick(); check("load20", 6'd20, 1'b0);
        set_ctl(1, 1, 1, 1, 0, 0, 0);
        tick(); check("clr_over_load", 6'd0, 1'b0);
        set_ctl(0, 1, 1, 0, 0, 1, 0); b = 32'd33;
        tick(); check("load_over_hold", 6'd33, 1'b0);
        set_ctl(1, 1, 0, 0, 0, 1, 0);
        tick(); check("hold_over_cnt0", 6'd33, 1'b0);
        tick(); check("hold_over_cnt1", 6'd33, 1'b0);

        // saturate up at 63, then hold clears result
        set_ctl(0, 1, 1, 0, 0, 0, 0); b = 32'd63;
        tick(); check("load63", 6'd63, 1'b0);
        set_ctl(1, 1, 0, 0, 0, 0, 1);
        tick(); check("satup_a", 6'd63, 1'b1);
        tick(); check("satup_b", 6'd63, 1'b1);
        set_ctl(1, 1, 0, 0, 0, 1, 1);
        tick(); check("hold_clr_res", 6'd63, 1'b0);

        // wrap down with step 10: 3-10 = -7 -> 57
        set_ctl(0, 0, 1, 0, 0, 0, 0); b = 32'd3;
        tick(); check("load3", 6'd3, 1'b0);
        set_ctl(1, 0, 0, 0, 1, 0, 0); b = 32'd10 << 16;
        tick(); check("wrapdn57", 6'd57, 1'b1);
        tick(); check("dn47", 6'd47, 1'b0);

        // step zero, then wrap up with step 20: 47+20 = 67 -> 3
        b = 32'd0;
        set_ctl(1, 1, 0, 0, 1, 0, 0);
        tick(); check("step0", 6'd47, 1'b0);
        b = (32'd20 << 16) | 32'hFFC0_FFC0;
        tick(); check("wrapup_step20", 6'd3, 1'b1);
        set_ctl(0, 1, 0, 0, 1, 0, 0);
        tick(); check("idle", 6'd3, 1'b0);

        // asynchronous reset between edges
        set_ctl(0, 1, 1, 0, 0, 0, 0); b = 32'd39;
        tick(); check("load39", 6'd39, 1'b0);
        set_ctl(1, 1, 0, 0, 0, 0, 0);
        tick(); check("up40", 6'd40, 1'b0);
        #2 reset = 1'b0;
        #1 check("async_rst", 6'd0, 1'b0);
        tick(); check("rst_low_edge", 6'd0, 1'b0);
        reset = 1'b1;
        tick(); check("post_rst_up1", 6'd1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
